// File: rtl/babbage_diff_engine_if.sv
// Start/operand/result bundle for babbage_diff_engine.
// BABBAGE_OVF_EN adds the ovf result flag.
interface babbage_diff_engine_if #(
   parameter int unsigned W   = 16,
   parameter int unsigned N_W = 8
);
   logic           start;
   logic [N_W-1:0] n;
   logic [W-1:0]   d0;
   logic [W-1:0]   d1;
   logic [W-1:0]   d2;
   logic [W-1:0]   d3;
   logic           ready;
   logic           busy;
   logic           done_tick;
   logic [W-1:0]   f;
`ifdef BABBAGE_OVF_EN
   logic           ovf;

   modport master (
      output start, n, d0, d1, d2, d3,
      input  ready, busy, done_tick, f, ovf
   );

   modport slave (
      input  start, n, d0, d1, d2, d3,
      output ready, busy, done_tick, f, ovf
   );
`else
   modport master (
      output start, n, d0, d1, d2, d3,
      input  ready, busy, done_tick, f
   );

   modport slave (
      input  start, n, d0, d1, d2, d3,
      output ready, busy, done_tick, f
   );
`endif
endinterface

// File: rtl/babbage_diff_engine.sv
// Third-order difference engine: evaluates a cubic at index n by repeated
// addition of finite differences. Optional BABBAGE_OVF_EN adds a wrap flag.
module babbage_diff_engine #(
   parameter int unsigned W   = 16,
   parameter int unsigned N_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   babbage_diff_engine_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   fr;
   logic [W-1:0]   gr;
   logic [W-1:0]   hr;
   logic [W-1:0]   cr;
   logic [N_W-1:0] cnt;
   logic [W-1:0]   f_q;
   logic           ready_q;
   logic           busy_q;
   logic           done_q;

   logic [W-1:0]   fr_next;
   logic [W-1:0]   gr_next;
   logic [W-1:0]   hr_next;

`ifdef BABBAGE_OVF_EN
   localparam int unsigned SW = W + 1;

   logic [SW-1:0]  sum_f;
   logic [SW-1:0]  sum_g;
   logic [SW-1:0]  sum_h;
   logic           step_carry;
   logic           ovf_acc;
   logic           ovf_q;

   // Widened sums expose the carry out of bit W-1 for each difference add.
   always_comb begin
      sum_f      = SW'(fr) + SW'(gr);
      sum_g      = SW'(gr) + SW'(hr);
      sum_h      = SW'(hr) + SW'(cr);
      fr_next    = sum_f[W-1:0];
      gr_next    = sum_g[W-1:0];
      hr_next    = sum_h[W-1:0];
      step_carry = sum_f[W] | sum_g[W] | sum_h[W];
   end

   // Sticky flag: cleared on accept, accumulates carries, published with f.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_acc <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) ovf_acc <= 1'b0;
            OP: begin
               if (cnt != '0) ovf_acc <= ovf_acc | step_carry;
               else           ovf_q   <= ovf_acc;
            end
            default: ;
         endcase
      end
   end

   assign bus.ovf = ovf_q;
`else
   always_comb begin
      fr_next = fr + gr;
      gr_next = gr + hr;
      hr_next = hr + cr;
   end
`endif

   // Control FSM and datapath; status outputs are registered with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         fr      <= '0;
         gr      <= '0;
         hr      <= '0;
         cr      <= '0;
         cnt     <= '0;
         f_q     <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  fr      <= bus.d0;
                  gr      <= bus.d1;
                  hr      <= bus.d2;
                  cr      <= bus.d3;
                  cnt     <= bus.n;
                  state   <= OP;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            OP: begin
               if (cnt != '0) begin
                  fr  <= fr_next;
                  gr  <= gr_next;
                  hr  <= hr_next;
                  cnt <= cnt - N_W'(1);
               end else begin
                  f_q    <= fr;
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.f         = f_q;
   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done_tick = done_q;

endmodule

// File: tb/tb_babbage_diff_engine.sv
// Directed bench for babbage_diff_engine: a W=16 and a W=8 instance.
// Define BABBAGE_OVF_EN to also check the ovf flag.
module tb_babbage_diff_engine;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc;
   int   busy_cnt;
   int   pulses;

   babbage_diff_engine_if #(.W(16), .N_W(8)) bus16 ();
   babbage_diff_engine_if #(.W(8),  .N_W(8)) bus8 ();

   babbage_diff_engine #(.W(16), .N_W(8)) dut (.clk(clk), .reset(reset), .bus(bus16));
   babbage_diff_engine #(.W(8),  .N_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waits for done_tick on bus16; cyc counts cycles from the start cycle.
   task automatic wait_done16();
      cyc = 1;
      busy_cnt = 0;
      while (bus16.done_tick !== 1'b1 && cyc < 400) begin
         if (bus16.busy === 1'b1) busy_cnt++;
         tick();
         cyc++;
      end
   endtask

   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic [7:0] nn,
                        input logic [15:0] exp_f);
      bus16.d0 = a; bus16.d1 = b; bus16.d2 = c; bus16.d3 = d; bus16.n = nn;
      bus16.start = 1'b1;
      tick();
      bus16.start = 1'b0;
      wait_done16();
      chk({tag, "_lat"}, 32'(cyc), 32'(nn) + 32'd2);
      chk({tag, "_busy"}, 32'(busy_cnt), 32'(nn) + 32'd1);
      chk({tag, "_f"}, 32'(bus16.f), 32'(exp_f));
`ifdef BABBAGE_OVF_EN
      chk({tag, "_ovf"}, 32'(bus16.ovf), 32'd0);
`endif
      tick();
      chk({tag, "_pulse"}, 32'(bus16.done_tick), 32'd0);
      chk({tag, "_ready"}, 32'(bus16.ready), 32'd1);
   endtask

   task automatic run8(input string tag, input logic [7:0] nn, input logic [7:0] exp_f,
                       input logic exp_ovf);
      bus8.d0 = 8'd0; bus8.d1 = 8'd1; bus8.d2 = 8'd6; bus8.d3 = 8'd6; bus8.n = nn;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      cyc = 1;
      while (bus8.done_tick !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
      chk({tag, "_lat"}, 32'(cyc), 32'(nn) + 32'd2);
      chk({tag, "_f"}, 32'(bus8.f), 32'(exp_f));
`ifdef BABBAGE_OVF_EN
      chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(exp_ovf));
`else
      if (exp_ovf) begin end
`endif
      tick();
   endtask

   initial begin
      bus16.start = 1'b0; bus16.n = '0;
      bus16.d0 = '0; bus16.d1 = '0; bus16.d2 = '0; bus16.d3 = '0;
      bus8.start = 1'b0; bus8.n = '0;
      bus8.d0 = '0; bus8.d1 = '0; bus8.d2 = '0; bus8.d3 = '0;

      tick(); tick();
      chk("rst_ready", 32'(bus16.ready), 32'd1);
      chk("rst_busy", 32'(bus16.busy), 32'd0);
      chk("rst_f", 32'(bus16.f), 32'd0);
      chk("rst_done", 32'(bus16.done_tick), 32'd0);
`ifdef BABBAGE_OVF_EN
      chk("rst_ovf", 32'(bus16.ovf), 32'd0);
`endif
      #3 reset = 1'b0;
      tick();

      // Legacy 2n^2+3n+5 and the n^3 cubic
      run16("legacy_n3", 16'd5, 16'd5, 16'd4, 16'd0, 8'd3, 16'd32);
      run16("legacy_n0", 16'd5, 16'd5, 16'd4, 16'd0, 8'd0, 16'd5);
      run16("cube_n4", 16'd0, 16'd1, 16'd6, 16'd6, 8'd4, 16'd64);

      // Narrow datapath: 216 fits, 343 wraps to 87
      run8("w8_n6", 8'd6, 8'd216, 1'b0);
      run8("w8_n7", 8'd7, 8'd87, 1'b1);

      // start and operand changes during OP are ignored
      bus16.d0 = 16'd5; bus16.d1 = 16'd5; bus16.d2 = 16'd4; bus16.d3 = 16'd0;
      bus16.n = 8'd10;
      bus16.start = 1'b1;
      tick();
      bus16.start = 1'b0;
      tick(); tick();
      bus16.start = 1'b1; bus16.d0 = 16'd99; bus16.n = 8'd1;
      tick();
      bus16.start = 1'b0; bus16.d0 = 16'd5;
      wait_done16();
      chk("ign_lat", 32'(cyc + 3), 32'd12);
      chk("ign_f", 32'(bus16.f), 32'd235);

      // Back-to-back: start in the first IDLE cycle after DONE
      tick();
      chk("b2b_ready", 32'(bus16.ready), 32'd1);
      chk("b2b_no_dup", 32'(bus16.done_tick), 32'd0);
      bus16.n = 8'd3;
      bus16.start = 1'b1;
      tick();
      bus16.start = 1'b0;
      chk("b2b_busy", 32'(bus16.busy), 32'd1);
      chk("b2b_f_hold", 32'(bus16.f), 32'd235);
      wait_done16();
      chk("b2b_lat", 32'(cyc), 32'd5);
      chk("b2b_f", 32'(bus16.f), 32'd32);
      tick();

      // Asynchronous reset mid-OP
      bus16.n = 8'd20;
      bus16.start = 1'b1;
      tick();
      bus16.start = 1'b0;
      tick(); tick(); tick();
      #2 reset = 1'b1;
      #1;
      chk("arst_ready", 32'(bus16.ready), 32'd1);
      chk("arst_busy", 32'(bus16.busy), 32'd0);
      chk("arst_f", 32'(bus16.f), 32'd0);
      chk("arst_done", 32'(bus16.done_tick), 32'd0);
      #2 reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus16.done_tick === 1'b1) pulses++;
      end
      chk("arst_no_done", 32'(pulses), 32'd0);
      run16("post_rst_n2", 16'd5, 16'd5, 16'd4, 16'd0, 8'd2, 16'd19);

      // Maximum index: counter must run all 255 steps without wrapping
      run16("max_n255", 16'd0, 16'd1, 16'd0, 16'd0, 8'd255, 16'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
